elevator_request_scheduler: RTL and testbench

ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

---
 rtl/elevator_request_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_elevator_request_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_request_scheduler.sv
// elevator_request_scheduler
//   Latches per-floor calls and runs a sweep (SCAN-style) scheduler that hands
//   one target floor at a time to the elevator controller, then holds the door
//   open for DWELL_CYCLES cycles once the car reaches that floor.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   call_req[3:0]  per-floor call pulses (bit i = floor i)
//   current_floor  floor the car is at
//   emergency_stop level; freezes dispatching, aborts trips and dwell
//   target_floor   registered target floor for the controller
//   up_request     one-cycle pulse: move up to target_floor
//   down_request   one-cycle pulse: move down to target_floor
//   pending[3:0]   latched outstanding calls
//   door_hold      high while dwelling at a serviced floor
//   sched_dir      sweep direction, 1 = up, 0 = down
//   sched_state    IDLE=00, DISPATCH=01, WAIT_ARRIVE=10, SERVICE=11
module elevator_request_scheduler #(
  parameter int unsigned DWELL_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] call_req,
  input  logic [1:0] current_floor,
  input  logic       emergency_stop,
  output logic [1:0] target_floor,
  output logic       up_request,
  output logic       down_request,
  output logic [3:0] pending,
  output logic       door_hold,
  output logic       sched_dir,
  output logic [1:0] sched_state
);

  localparam int unsigned NUM_FLOORS = 4;
  localparam int unsigned FLOOR_W    = 2;
  localparam int unsigned CNT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_DISPATCH = 2'b01,
    ST_WAIT     = 2'b10,
    ST_SERVICE  = 2'b11
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [FLOOR_W-1:0]    target_q, target_d;
  logic                  dir_q, dir_d;
  logic                  up_q, up_d;
  logic                  down_q, down_d;
  logic                  door_q, door_d;
  logic [CNT_W-1:0]      dwell_q, dwell_d;

  // Nearest pending floor strictly above / strictly below the car
  logic                  above_hit, below_hit;
  logic [FLOOR_W-1:0]    above_floor, below_floor;

  always_comb begin
    above_hit   = 1'b0;
    below_hit   = 1'b0;
    above_floor = '0;
    below_floor = '0;
    // Downward scan leaves the lowest floor above the car
    for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
      if (pending_q[FLOOR_W'(i)] && (FLOOR_W'(i) > current_floor)) begin
        above_hit   = 1'b1;
        above_floor = FLOOR_W'(i);
      end
    end
    // Upward scan leaves the highest floor below the car
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (pending_q[FLOOR_W'(i)] && (FLOOR_W'(i) < current_floor)) begin
        below_hit   = 1'b1;
        below_floor = FLOOR_W'(i);
      end
    end
  end

  // Next-state, pending bookkeeping and next values of the registered outputs
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | call_req;
    target_d  = target_q;
    dir_d     = dir_q;
    up_d      = 1'b0;
    down_d    = 1'b0;
    door_d    = 1'b0;
    dwell_d   = '0;

    // Calls for the floor being serviced are dropped while the door is held
    if (state_q == ST_SERVICE) begin
      pending_d[target_q] = 1'b0;
    end

    if (emergency_stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pending_q != '0) begin
            if (pending_q[current_floor]) begin
              state_d                  = ST_SERVICE;
              target_d                 = current_floor;
              door_d                   = 1'b1;
              pending_d[current_floor] = 1'b0;
            end else begin
              // Continue the sweep; reverse only when nothing lies ahead
              if (dir_q) begin
                if (above_hit) begin
                  target_d = above_floor;
                end else begin
                  dir_d    = 1'b0;
                  target_d = below_floor;
                end
              end else begin
                if (below_hit) begin
                  target_d = below_floor;
                end else begin
                  dir_d    = 1'b1;
                  target_d = above_floor;
                end
              end
              state_d = ST_DISPATCH;
              up_d    = (target_d > current_floor);
              down_d  = ~up_d;
            end
          end
        end
        ST_DISPATCH: begin
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (current_floor == target_q) begin
            state_d             = ST_SERVICE;
            door_d              = 1'b1;
            pending_d[target_q] = 1'b0;
          end
        end
        ST_SERVICE: begin
          if (dwell_q == CNT_W'(DWELL_CYCLES - 1)) begin
            state_d = ST_IDLE;
          end else begin
            door_d  = 1'b1;
            dwell_d = dwell_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      target_q  <= '0;
      dir_q     <= 1'b1;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      door_q    <= 1'b0;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      target_q  <= target_d;
      dir_q     <= dir_d;
      up_q      <= up_d;
      down_q    <= down_d;
      door_q    <= door_d;
      dwell_q   <= dwell_d;
    end
  end

  assign target_floor = target_q;
  assign up_request   = up_q;
  assign down_request = down_q;
  assign pending      = pending_q;
  assign door_hold    = door_q;
  assign sched_dir    = dir_q;
  assign sched_state  = state_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Testbench for elevator_request_scheduler.
// Stimulus pushes expected events (up/down pulse, service start) with the
// cycle they must appear on; the monitor pops and compares whenever the DUT
// presents a pulse or a rising door_hold.
module tb_elevator_request_scheduler;

  localparam int DWELL = 8;
  localparam logic [1:0] K_UP  = 2'd1;
  localparam logic [1:0] K_DN  = 2'd2;
  localparam logic [1:0] K_SVC = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  floor;
    logic        dir;
    logic [3:0]  pend;
    logic [31:0] cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] call_req;
  logic [1:0] current_floor;
  logic       emergency_stop;
  logic [1:0] target_floor;
  logic       up_request;
  logic       down_request;
  logic [3:0] pending;
  logic       door_hold;
  logic       sched_dir;
  logic [1:0] sched_state;

  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc   = 0;
  ev_t sb[$];

  elevator_request_scheduler #(.DWELL_CYCLES(DWELL)) dut (
    .clk            (clk),
    .reset          (reset),
    .call_req       (call_req),
    .current_floor  (current_floor),
    .emergency_stop (emergency_stop),
    .target_floor   (target_floor),
    .up_request     (up_request),
    .down_request   (down_request),
    .pending        (pending),
    .door_hold      (door_hold),
    .sched_dir      (sched_dir),
    .sched_state    (sched_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [1:0] f,
                           input logic d, input logic [3:0] p, input int delta);
    ev_t e;
    e.kind  = k;
    e.floor = f;
    e.dir   = d;
    e.pend  = p;
    e.cyc   = 32'(cyc + delta);
    sb.push_back(e);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"},  int'(sched_state),  0);
    chk({tag, "_pend"},   int'(pending),      0);
    chk({tag, "_target"}, int'(target_floor), 0);
    chk({tag, "_dir"},    int'(sched_dir),    1);
    chk({tag, "_up"},     int'(up_request),   0);
    chk({tag, "_down"},   int'(down_request), 0);
    chk({tag, "_door"},   int'(door_hold),    0);
  endtask

  // Monitor: pops one expected event per observed pulse / door rise
  logic door_prev = 1'b0;
  int   door_len  = 0;
  always @(negedge clk) begin
    ev_t e;
    logic [1:0] k;
    if (!reset) begin
      door_prev = 1'b0;
      door_len  = 0;
    end else begin
      if (up_request || down_request || (door_hold && !door_prev)) begin
        if (up_request || down_request)
          chk("single_pulse", int'(up_request & down_request), 0);
        k = up_request ? K_UP : (down_request ? K_DN : K_SVC);
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_event: got kind %0d floor %0d, required none (cycle %0d)",
                   k, target_floor, cyc);
        end else begin
          e = sb.pop_front();
          chk("ev_kind",  int'(k),            int'(e.kind));
          chk("ev_floor", int'(target_floor), int'(e.floor));
          chk("ev_dir",   int'(sched_dir),    int'(e.dir));
          chk("ev_pend",  int'(pending),      int'(e.pend));
          chk("ev_cycle", cyc,                int'(e.cyc));
        end
      end
      if (door_hold) door_len++;
      if (door_prev && !door_hold) begin
        chk("dwell_len", door_len, DWELL);
        door_len = 0;
      end
      door_prev = door_hold;
    end
  end

  initial begin
    reset          = 1'b0;
    call_req       = 4'b0000;
    current_floor  = 2'd0;
    emergency_stop = 1'b0;
    step(2);
    chk_reset_values("rst");
    reset = 1'b1;
    step(2);

    // Floor 0, call at 3: up pulse after 2 edges, dwell at 3
    call_req = 4'b1000;
    expect_ev(K_UP, 2'd3, 1'b1, 4'b1000, 2);
    step(1);
    call_req = 4'b0000;
    chk("a_pend_latched", int'(pending), 4'b1000);
    chk("a_state_idle",   int'(sched_state), 0);
    step(1);
    chk("a_state_disp",   int'(sched_state), 1);
    step(2);
    chk("a_state_wait",   int'(sched_state), 2);
    current_floor = 2'd3;
    expect_ev(K_SVC, 2'd3, 1'b1, 4'b0000, 1);
    step(1);
    chk("a_state_svc",    int'(sched_state), 3);
    step(10);
    chk("a_back_idle",    int'(sched_state), 0);

    // From floor 3 going up: reverse to floor 0, emergency in WAIT_ARRIVE
    call_req = 4'b0001;
    expect_ev(K_DN, 2'd0, 1'b0, 4'b0001, 2);
    step(1);
    call_req = 4'b0000;
    step(2);
    emergency_stop = 1'b1;
    step(1);
    chk("e_state_idle", int'(sched_state),  0);
    chk("e_pend_kept",  int'(pending),      4'b0001);
    chk("e_target",     int'(target_floor), 0);
    step(1);
    chk("e_still_idle", int'(sched_state),  0);
    emergency_stop = 1'b0;
    expect_ev(K_DN, 2'd0, 1'b0, 4'b0001, 1);
    step(3);
    current_floor = 2'd0;
    expect_ev(K_SVC, 2'd0, 1'b0, 4'b0000, 1);
    step(12);

    // Call at the current floor: direct service, no pulse
    call_req = 4'b0001;
    expect_ev(K_SVC, 2'd0, 1'b0, 4'b0000, 2);
    step(1);
    call_req = 4'b0000;
    step(12);

    // Floor 0 going down, call at 2: reverse up; drop calls for 2 while serviced
    call_req = 4'b0100;
    expect_ev(K_UP, 2'd2, 1'b1, 4'b0100, 2);
    step(1);
    call_req = 4'b0000;
    step(2);
    current_floor = 2'd2;
    call_req      = 4'b0100;
    expect_ev(K_SVC, 2'd2, 1'b1, 4'b0000, 1);
    step(1);
    call_req = 4'b1100;
    step(1);
    call_req = 4'b0000;
    chk("f_drop_floor2", int'(pending),   4'b1000);
    chk("f_door_high",   int'(door_hold), 1);
    step(1);

    // Reset in the middle of SERVICE
    reset = 1'b0;
    #1;
    chk_reset_values("rst_svc");
    current_floor = 2'd1;
    step(2);
    reset = 1'b1;
    step(4);
    chk("r_stay_idle", int'(sched_state), 0);
    chk("r_pend_zero", int'(pending),     0);

    // Floor 1 going up with calls at 0 and 2: serve 2, then reverse to 0
    call_req = 4'b0101;
    expect_ev(K_UP, 2'd2, 1'b1, 4'b0101, 2);
    step(1);
    call_req = 4'b0000;
    step(2);
    current_floor = 2'd2;
    expect_ev(K_SVC, 2'd2, 1'b1, 4'b0001, 1);
    expect_ev(K_DN,  2'd0, 1'b0, 4'b0001, 10);
    step(12);
    current_floor = 2'd0;
    expect_ev(K_SVC, 2'd0, 1'b0, 4'b0000, 1);
    step(12);
    chk("b_final_idle", int'(sched_state), 0);
    chk("b_final_dir",  int'(sched_dir),   0);

    chk("events_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
